// File: rtl/gate_chk_pkg.sv
// Shared types and err-vector bit indices for the gate result checker.
// Bit order of err follows the gate port order of the checked DUT.
package gate_chk_pkg;
    localparam int NUM_GATES = 10;
    localparam int ERR_AND   = 0;
    localparam int ERR_OR    = 1;
    localparam int ERR_NOTA  = 2;
    localparam int ERR_NOTB  = 3;
    localparam int ERR_XOR   = 4;
    localparam int ERR_XNOR  = 5;
    localparam int ERR_BUFA  = 6;
    localparam int ERR_BUFB  = 7;
    localparam int ERR_NAND  = 8;
    localparam int ERR_NOR   = 9;

    typedef struct packed {
        logic [1:0]           ab;
        logic [NUM_GATES-1:0] err;
    } gate_rec_t;
endpackage

// File: rtl/gate_chk_fifo.sv
// Show-ahead synchronous FIFO of gate_rec_t records; head reads as zero when empty.
// Push is ignored when full and pop when empty, so a full FIFO never admits a same-cycle push.
module gate_chk_fifo
    import gate_chk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  gate_rec_t i_wdat,
    input  logic      i_pop,
    output gate_rec_t o_rdat,
    output logic      o_full,
    output logic      o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    gate_rec_t   r_mem [DEPTH];
    logic        w_full;
    logic        w_empty;
    logic        w_wr_en;
    logic        w_rd_en;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_wr_en = i_push && !w_full;
    assign w_rd_en = i_pop && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdat;
    end

    assign o_rdat  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
endmodule

// File: rtl/gate_result_checker.sv
// Recomputes expected gate outputs from a/b, queues {ab, err} records and keeps
// saturating pass/fail/drop counters plus a sticky overflow flag.
module gate_result_checker
    import gate_chk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             andd,
    input  logic             orr,
    input  logic             nott_a,
    input  logic             nott_b,
    input  logic             xorr,
    input  logic             xnorr,
    input  logic             buff_a,
    input  logic             buff_b,
    input  logic             nandd,
    input  logic             norr,
    input  logic             cnt_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_ab,
    output logic [9:0]       out_err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_GATES-1:0] w_err;
    gate_rec_t            w_wr_rec;
    gate_rec_t            w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic [CNT_W-1:0]     r_pass_cnt;
    logic [CNT_W-1:0]     r_fail_cnt;
    logic [CNT_W-1:0]     r_drop_cnt;
    logic                 r_overflow;

    // Case-inequality so an X/Z on a DUT output registers as a mismatch.
    always_comb begin
        w_err           = '0;
        w_err[ERR_AND]  = (andd   !== (a & b));
        w_err[ERR_OR]   = (orr    !== (a | b));
        w_err[ERR_NOTA] = (nott_a !== ~a);
        w_err[ERR_NOTB] = (nott_b !== ~b);
        w_err[ERR_XOR]  = (xorr   !== (a ^ b));
        w_err[ERR_XNOR] = (xnorr  !== ~(a ^ b));
        w_err[ERR_BUFA] = (buff_a !== a);
        w_err[ERR_BUFB] = (buff_b !== b);
        w_err[ERR_NAND] = (nandd  !== ~(a & b));
        w_err[ERR_NOR]  = (norr   !== ~(a | b));
    end

    assign w_wr_rec = '{ab: {a, b}, err: w_err};
    assign w_push   = in_valid && !w_full;
    assign w_drop   = in_valid && w_full;
    assign w_pop    = out_ready && !w_empty;

    gate_chk_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdat  (w_wr_rec),
        .i_pop   (w_pop),
        .o_rdat  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (cnt_clr) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push && (w_err == '0) && (r_pass_cnt != '1)) r_pass_cnt <= r_pass_cnt + CNT_ONE;
            if (w_push && (w_err != '0) && (r_fail_cnt != '1)) r_fail_cnt <= r_fail_cnt + CNT_ONE;
            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_ONE;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_ab    = w_head.ab;
    assign out_err   = w_head.err;
    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign overflow  = r_overflow;
endmodule

// File: doc/gate_result_checker.md
# gate_result_checker

Downstream checking stage for the logic-gate DUT. Each cycle it can capture the DUT's two inputs and ten gate outputs, and recompute the expected gate values from the captured inputs. Results are buffered as records `{ab, err}` in a small FIFO drained through a valid/ready port, with running pass/fail/drop counters kept alongside. It sits between the gate DUT interface signals and the scoreboard/reporting logic.

## Interface
- `DEPTH`, 4: result FIFO entries, power of two, ≥2
- `CNT_W`, 16: width of pass/fail/drop counters

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  current a/b/gate outputs are settled and to be checked
- `in_ready`  out  1  FIFO can accept a record
- `a`, `b`  in  1 each  DUT inputs
- `andd`, `orr`, `nott_a`, `nott_b`, `xorr`, `xnorr`, `buff_a`, `buff_b`, `nandd`, `norr`  in  1 each  DUT outputs
- `cnt_clr`  in  1  synchronous clear of all counters and `overflow`
- `out_valid`  out  1  head record available
- `out_ready`  in  1  consumer accepts head record
- `out_ab`  out  2  captured `{a,b}` of head record
- `out_err`  out  10  per-gate mismatch vector of head record
- `pass_cnt`, `fail_cnt`, `drop_cnt`  out  CNT_W each  saturating counters
- `overflow`  out  1  sticky: a valid sample was dropped

## Operation
- Expected values (from `a`, `b`): and, or, ~a, ~b, xor, xnor, a, b, nand, nor.
- `err` bit order:
  - 0 andd, 1 orr, 2 nott_a, 3 nott_b, 4 xorr, 5 xnorr
  - 6 buff_a, 7 buff_b, 8 nandd, 9 norr
- A bit is set when the DUT output differs from the expected value. X/Z on a DUT output counts as a mismatch (4-state compare).
- Push: `in_valid && in_ready`.
  - Write `{ab, err}` to the FIFO.
  - `pass_cnt++` if `err==0`, else `fail_cnt++`.
- Drop: `in_valid && !in_ready`.
  - Nothing is written.
  - `drop_cnt++`; `overflow` is set and stays set.
- Pop: `out_valid && out_ready` advances the head.
- `in_ready = (occupancy < DEPTH)`, combinational from occupancy only. When the FIFO is full, a same-cycle pop does not admit a push.
- `out_valid = (occupancy != 0)`. `out_ab`/`out_err` come straight from the head entry (show-ahead).
- Counters saturate at 2^CNT_W−1; further events leave them unchanged.
- Counter update priority: `rst` > `cnt_clr` > increment. On a `cnt_clr` cycle the current event is not counted. `cnt_clr` does not touch the FIFO.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and LSBs equal; empty = pointers equal.
- DUT input `temp` is not monitored.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=1, `out_ab`=0, `out_err`=0
  - all counters 0, `overflow`=0, pointers 0
- Reset asserted mid-operation discards FIFO contents immediately (asynchronous).
- Latency: a sample pushed at edge N is presented with `out_valid`=1 after edge N (the next cycle) if the FIFO was empty. No combinational path from `in_*` to `out_*`.
- Counters and `overflow` reflect an event at edge N from the cycle after edge N.
- Simultaneous push and pop with occupancy in 1..DEPTH−1: occupancy is unchanged and both operations take effect.
- Push when empty plus `out_ready`=1: no pop that cycle, since `out_valid` was 0.
- Output data stays stable while `out_valid && !out_ready`.

## Structure
- Package `gate_chk_pkg` holds:
  - localparams `ERR_AND`…`ERR_NOR` (bit indices 0–9) and `NUM_GATES`=10
  - `typedef struct packed {logic [1:0] ab; logic [NUM_GATES-1:0] err;} gate_rec_t`
- Sub-module `gate_chk_fifo` is a parameterised synchronous FIFO of `gate_rec_t` with full/empty and push/pop. Expected-value compute and the counters live in the top.

## Test plan
- Exhaustive good DUT: drive a,b = 00,01,10,11 with correct outputs, `out_ready`=1.
  - Expect 4 records with `out_err`=0, `out_ab` in the same order.
  - Expect `pass_cnt`=4, `fail_cnt`=0.
- Fault inject: a=1, b=0, `xorr`=0.
  - Expect `out_err`=10'h010, `fail_cnt`=1.
  - Repeat with `norr`=X: expect `out_err`=10'h200.
- Backpressure: `out_ready`=0, push 6 samples with DEPTH=4.
  - `in_ready` drops after the 4th push.
  - `drop_cnt`=2, `overflow`=1.
  - Draining returns the first 4 samples in order.
- Full + pop: FIFO full, `in_valid`=1 and `out_ready`=1 in the same cycle.
  - The pop occurs, the push is dropped (`drop_cnt`+1), occupancy becomes 3.
- Saturation/clear with CNT_W=2: 5 good samples give `pass_cnt`=3.
  - `cnt_clr` with a coincident sample leaves all counters 0 and `overflow` 0, and the sample is still written to the FIFO.
- Async reset while 3 records are queued: `out_valid` falls before the next edge; after release `in_ready`=1 and the counters are 0.
